// File: rtl/dff_universal_reg.sv
// Universal shift/load register with edge flags, STAGES-deep history line and a history-valid flag.
// Q updates one edge after inputs; Q_dly trails Q by STAGES edges; no backpressure, all state free-runs on Clk.
module dff_universal_reg #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SinL,
    input  logic             SinR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_dly,
    output logic             Dly_valid,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SHR  = 2'b11
    } mode_e;

    localparam int              CNT_W   = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STAGES);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_q_prev;
    logic [WIDTH-1:0] r_dly [STAGES];
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_q_nxt;
    mode_e            w_mode;

    assign w_mode = mode_e'(Mode);

    always_comb begin
        w_q_nxt = r_q;
        if (En) begin
            case (w_mode)
                MODE_HOLD: w_q_nxt = r_q;
                MODE_LOAD: w_q_nxt = D;
                MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], SinL};
                MODE_SHR:  w_q_nxt = {SinR, r_q[WIDTH-1:1]};
                default:   w_q_nxt = r_q;
            endcase
        end
    end

    // Q_prev, the history line and the counter ignore En so edge flags and
    // delayed history stay aligned to real clock edges.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_q      <= '0;
            r_q_prev <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_q      <= w_q_nxt;
            r_q_prev <= r_q;
            r_dly[0] <= r_q;
            for (int i = 1; i < STAGES; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign Q         = r_q;
    assign Q_dly     = r_dly[STAGES-1];
    assign Dly_valid = (r_cnt == CNT_MAX);
    assign Rise      = r_q & ~r_q_prev;
    assign Fall      = ~r_q & r_q_prev;

endmodule

// File: tb/tb_dff_universal_reg.sv
// Scoreboard bench for dff_universal_reg at WIDTH=8, STAGES=3: each driven cycle queues its
// expected outputs, which are popped and compared one edge later, plus literal vector checks.
module tb_dff_universal_reg;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       En = 1'b0;
    logic [1:0] Mode = 2'b00;
    logic [7:0] D = 8'h00;
    logic       SinL = 1'b0;
    logic       SinR = 1'b0;
    logic [7:0] Q, Q_dly, Rise, Fall;
    logic       Dly_valid;

    dff_universal_reg #(.WIDTH(8), .STAGES(3)) dut (
        .Clk(Clk), .Rst(Rst), .En(En), .Mode(Mode), .D(D), .SinL(SinL), .SinR(SinR),
        .Q(Q), .Q_dly(Q_dly), .Dly_valid(Dly_valid), .Rise(Rise), .Fall(Fall)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] qdly;
        logic       vld;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference state
    logic [7:0] m_q = 8'h00;
    logic [7:0] m_prev = 8'h00;
    logic [7:0] m_dly [3] = '{8'h00, 8'h00, 8'h00};
    int         m_cnt = 0;

    function automatic obs_t sample();
        obs_t o;
        o.q = Q; o.rise = Rise; o.fall = Fall; o.qdly = Q_dly; o.vld = Dly_valid;
        return o;
    endfunction

    // Drive one cycle, queue the expected post-edge outputs, then step past the edge.
    task automatic drive(input logic rst, input logic en, input logic [1:0] mode,
                         input logic [7:0] d, input logic sl, input logic sr);
        obs_t e;
        Rst = rst; En = en; Mode = mode; D = d; SinL = sl; SinR = sr;
        if (rst) begin
            m_q = 8'h00; m_prev = 8'h00; m_cnt = 0;
            m_dly[0] = 8'h00; m_dly[1] = 8'h00; m_dly[2] = 8'h00;
        end else begin
            m_dly[2] = m_dly[1]; m_dly[1] = m_dly[0]; m_dly[0] = m_q;
            m_prev = m_q;
            if (en) begin
                case (mode)
                    2'b01: m_q = d;
                    2'b10: m_q = {m_q[6:0], sl};
                    2'b11: m_q = {sr, m_q[7:1]};
                    default: m_q = m_q;
                endcase
            end
            if (m_cnt < 3) m_cnt++;
        end
        e.q = m_q; e.rise = m_q & ~m_prev; e.fall = ~m_q & m_prev;
        e.qdly = m_dly[2]; e.vld = (m_cnt >= 3);
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, o;
        drive(1'b1, 1'b1, 2'b01, 8'hFF, 1'b1, 1'b1);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_sb: got %h want %h", o, e); end
        checks++;
        if ({Q, Q_dly, Rise, Fall, Dly_valid} !== 33'h0) begin
            errors++; $display("FAIL reset_zero: got q=%h qdly=%h rise=%h fall=%h vld=%b want all 0",
                               Q, Q_dly, Rise, Fall, Dly_valid);
        end
    endtask

    task automatic test_load();
        obs_t e, o;
        drive(1'b0, 1'b1, 2'b01, 8'hA5, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL load_sb: got %h want %h", o, e); end
        checks++;
        if (Q !== 8'hA5 || Rise !== 8'hA5 || Fall !== 8'h00) begin
            errors++; $display("FAIL load_vec: got q=%h rise=%h fall=%h want a5 a5 00", Q, Rise, Fall);
        end
        drive(1'b0, 1'b1, 2'b00, 8'h3C, 1'b1, 1'b1);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL hold_sb: got %h want %h", o, e); end
        checks++;
        if (Q !== 8'hA5 || Rise !== 8'h00) begin
            errors++; $display("FAIL hold_vec: got q=%h rise=%h want a5 00", Q, Rise);
        end
    endtask

    task automatic test_shift_left();
        obs_t e, o;
        logic [7:0] want [4];
        want[0] = 8'h03; want[1] = 8'h07; want[2] = 8'h0F; want[3] = 8'h1F;
        drive(1'b0, 1'b1, 2'b01, 8'h81, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0);
            e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL shl_sb[%0d]: got %h want %h", i, o, e); end
            checks++;
            if (Q !== want[i] || Fall !== ((i == 0) ? 8'h80 : 8'h00)) begin
                errors++; $display("FAIL shl_vec[%0d]: got q=%h fall=%h want q=%h fall=%h",
                                   i, Q, Fall, want[i], (i == 0) ? 8'h80 : 8'h00);
            end
        end
    endtask

    task automatic test_shift_right();
        obs_t e, o;
        drive(1'b0, 1'b1, 2'b01, 8'h81, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        drive(1'b0, 1'b1, 2'b11, 8'h00, 1'b1, 1'b0);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL shr_sb: got %h want %h", o, e); end
        checks++;
        if (Q !== 8'h40 || Rise !== 8'h40 || Fall !== 8'h81) begin
            errors++; $display("FAIL shr_vec: got q=%h rise=%h fall=%h want 40 40 81", Q, Rise, Fall);
        end
    endtask

    task automatic test_enable();
        obs_t e, o;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 2'b01, 8'hFF, 1'b1, 1'b1);
            e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL en_sb[%0d]: got %h want %h", i, o, e); end
            checks++;
            if (Q !== 8'h40 || Rise !== 8'h00 || Fall !== 8'h00) begin
                errors++; $display("FAIL en_vec[%0d]: got q=%h rise=%h fall=%h want 40 00 00",
                                   i, Q, Rise, Fall);
            end
        end
    endtask

    task automatic test_delay();
        obs_t e, o;
        logic [7:0] dat  [4];
        logic [7:0] qdly [7];
        logic       vld  [7];
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
        qdly[0] = 8'h00; qdly[1] = 8'h00; qdly[2] = 8'h00; qdly[3] = 8'h11;
        qdly[4] = 8'h22; qdly[5] = 8'h33; qdly[6] = 8'h44;
        vld[0] = 1'b0; vld[1] = 1'b0; vld[2] = 1'b1; vld[3] = 1'b1;
        vld[4] = 1'b1; vld[5] = 1'b1; vld[6] = 1'b1;
        drive(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, (i < 4) ? 2'b01 : 2'b00, (i < 4) ? dat[i] : 8'h00, 1'b0, 1'b0);
            e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL dly_sb[%0d]: got %h want %h", i, o, e); end
            checks++;
            if (Q_dly !== qdly[i] || Dly_valid !== vld[i]) begin
                errors++; $display("FAIL dly_vec[%0d]: got qdly=%h vld=%b want qdly=%h vld=%b",
                                   i, Q_dly, Dly_valid, qdly[i], vld[i]);
            end
        end
    endtask

    task automatic test_midreset();
        obs_t e, o;
        drive(1'b0, 1'b1, 2'b01, 8'hF0, 1'b0, 1'b0);
        void'(exp_q.pop_front());
        Rst = 1'b1;
        #2;
        checks++;
        if (Q !== 8'hF0) begin
            errors++; $display("FAIL rst_async: got q=%h want f0 between edges", Q);
        end
        drive(1'b1, 1'b1, 2'b01, 8'hFF, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL midrst_sb: got %h want %h", o, e); end
        checks++;
        if (Q !== 8'h00 || Q_dly !== 8'h00 || Dly_valid !== 1'b0 || Fall !== 8'h00) begin
            errors++; $display("FAIL midrst_vec: got q=%h qdly=%h vld=%b fall=%h want 00 00 0 00",
                               Q, Q_dly, Dly_valid, Fall);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom));
            e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL rand_sb[%0d]: got %h want %h", i, o, e); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_load();
        test_shift_left();
        test_shift_right();
        test_enable();
        test_delay();
        test_midreset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_universal_reg.md
DFF_UNIVERSAL_REG -- requirements
Module: dff_universal_reg

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter STAGES, default 3, setting the delay-line depth in cycles (legal range 1..16).
Ports:
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port En, input, 1 bit: clock enable for the main register.
REQ-006 The block SHALL have port Mode, input, 2 bits: 00 hold, 01 parallel load, 10 shift left, 11 shift right.
REQ-007 The block SHALL have port D, input, WIDTH bits: parallel load data.
REQ-008 The block SHALL have port SinL, input, 1 bit: serial-in to bit 0 on shift left.
REQ-009 The block SHALL have port SinR, input, 1 bit: serial-in to bit WIDTH-1 on shift right.
REQ-010 The block SHALL have port Q, output, WIDTH bits: main register contents.
REQ-011 The block SHALL have port Q_dly, output, WIDTH bits: Q delayed by STAGES cycles.
REQ-012 The block SHALL have port Dly_valid, output, 1 bit: high once Q_dly reflects post-reset Q history.
REQ-013 The block SHALL have port Rise, output, WIDTH bits: per-bit 0->1 transition flags of Q.
REQ-014 The block SHALL have port Fall, output, WIDTH bits: per-bit 1->0 transition flags of Q.

Function
REQ-015 On a rising Clk edge with Rst=0 and En=1, Q SHALL update per Mode: 00 Q unchanged; 01 Q<=D; 10 Q<={Q[WIDTH-2:0],SinL}; 11 Q<={SinR,Q[WIDTH-1:1]}.
REQ-016 With Rst=0 and En=0, Q SHALL hold regardless of Mode, D, SinL, SinR.
REQ-017 Q SHALL change only on the rising Clk edge; no level-sensitive (latch) path from D or Mode to Q.
REQ-018 Shifts SHALL discard the bit shifted out (Q[WIDTH-1] on left, Q[0] on right); no wrap-around.
REQ-019 The block SHALL hold a previous-value register Q_prev, loaded with Q every rising edge independent of En.
REQ-020 Rise SHALL equal Q & ~Q_prev and Fall SHALL equal ~Q & Q_prev, both combinational, so each flag is high for exactly one cycle following the edge that changed that bit.
REQ-021 A bit that does not change (including during hold or En=0) SHALL produce no Rise/Fall pulse.
REQ-022 The delay line SHALL be STAGES registers clocked every rising edge independent of En; stage 0 takes Q, Q_dly is the last stage, giving Q_dly(t)=Q(t-STAGES).
REQ-023 A saturating counter SHALL count rising edges since reset release; Dly_valid SHALL be 0 until STAGES edges have elapsed with Rst=0, then 1 until the next reset.

Reset
REQ-024 While Rst=1 at a rising edge, Q, Q_prev, every delay stage and the valid counter SHALL clear to 0, overriding En and Mode.
REQ-025 After reset, Q, Q_dly, Rise, Fall and Dly_valid SHALL all read 0.
REQ-026 Rst asserted mid-operation SHALL take effect at the next rising edge with no Fall pulses for bits cleared by reset (Q_prev also cleared).
REQ-027 Rst has no asynchronous effect; outputs SHALL hold between edges while Rst rises.

Verification (WIDTH=8, STAGES=3)
REQ-028 Rst=1 one edge, then Rst=0, En=1, Mode=01, D=8'hA5 -> Q=8'hA5 after one edge; Rise=8'hA5 for that cycle only, Fall=0.
REQ-029 From Q=8'h81, Mode=10, SinL=1, four edges -> Q: 03, 07, 0F, 1F; Fall=8'h80 after first edge only.
REQ-030 From Q=8'h81, Mode=11, SinR=0, one edge -> Q=8'h40; Rise=8'h40, Fall=8'h81.
REQ-031 En=0, Mode=01, D=8'hFF for 5 edges -> Q unchanged, Rise=Fall=0 throughout.
REQ-032 Load 11,22,33,44 on consecutive edges after reset -> Dly_valid rises on the third edge after reset release; Q_dly shows 11 three cycles after Q shows 11, then 22, 33, 44 in order.
REQ-033 Q=8'hF0, Rst=1 for one edge -> Q=0, Q_dly=0, Dly_valid=0, Fall=0 in the next cycle.
